// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, the ALU operation encoding consumed by execute,
// operand select encodings and the decoded bundle carried from decode to execute.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_A_RS1  = 2'b00,
      SRC_A_PC   = 2'b01,
      SRC_A_ZERO = 2'b10
   } src_a_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } src_b_e;

   typedef struct packed {
      alu_op_e     alu_op;
      src_a_e      src_a;
      src_b_e      src_b;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic [2:0]  funct3;
      logic        illegal;
   } decode_t;

   localparam int DEC_W = $bits(decode_t);

   // alt is funct7[5]; it only matters for the add/sub and srl/sra pairs.
   function automatic alu_op_e alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_decode_logic.sv
// Purely combinational RV32I decoder: instruction word to execute bundle.
// Illegal encodings come out as an add with every side-effect enable cleared.
module rv32i_decode_logic
   import rv32i_pkg::*;
(
   input  logic [31:0]      instr,
   output logic [DEC_W-1:0] dec_o
);

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        illegal;
   decode_t     d;

   assign opcode = instr[6:0];
   assign funct7 = instr[31:25];
   assign funct3 = instr[14:12];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   always_comb begin
      d        = '0;
      illegal  = 1'b0;
      d.rs1    = instr[19:15];
      d.rs2    = instr[24:20];
      d.rd     = instr[11:7];
      d.funct3 = funct3;
      d.alu_op = ALU_ADD;
      d.src_a  = SRC_A_RS1;
      d.src_b  = SRC_B_RS2;
      case (opcode)
         OPC_OP: begin
            d.alu_op = alu_op_from_funct3(funct3, funct7[5]);
            d.rd_we  = 1'b1;
            illegal  = !((funct7 == F7_ZERO) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OPC_OP_IMM: begin
            // funct3=000 is addi regardless of the immediate's top bits.
            d.alu_op = alu_op_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
            d.src_b  = SRC_B_IMM;
            d.imm    = imm_i;
            d.rd_we  = 1'b1;
            if (funct3 == 3'b001) begin
               illegal = (funct7 != F7_ZERO);
            end else if (funct3 == 3'b101) begin
               illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
         end
         OPC_LOAD: begin
            d.src_b  = SRC_B_IMM;
            d.imm    = imm_i;
            d.mem_rd = 1'b1;
            d.rd_we  = 1'b1;
         end
         OPC_STORE: begin
            d.src_b  = SRC_B_IMM;
            d.imm    = imm_s;
            d.mem_wr = 1'b1;
         end
         OPC_BRANCH: begin
            d.imm    = imm_b;
            d.branch = 1'b1;
            if (funct3[2:1] == 2'b00) begin
               d.alu_op = ALU_SUB;
            end else if (funct3[2:1] == 2'b10) begin
               d.alu_op = ALU_SLT;
            end else if (funct3[2:1] == 2'b11) begin
               d.alu_op = ALU_SLTU;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            d.src_a = SRC_A_ZERO;
            d.src_b = SRC_B_IMM;
            d.imm   = imm_u;
            d.rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            d.src_a = SRC_A_PC;
            d.src_b = SRC_B_IMM;
            d.imm   = imm_u;
            d.rd_we = 1'b1;
         end
         OPC_JAL: begin
            d.src_a = SRC_A_PC;
            d.src_b = SRC_B_FOUR;
            d.imm   = imm_j;
            d.jump  = 1'b1;
            d.rd_we = 1'b1;
         end
         OPC_JALR: begin
            d.src_a = SRC_A_PC;
            d.src_b = SRC_B_FOUR;
            d.imm   = imm_i;
            d.jump  = 1'b1;
            d.jalr  = 1'b1;
            d.rd_we = 1'b1;
            illegal = (funct3 != 3'b000);
         end
         OPC_FENCE: begin
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         d.alu_op = ALU_ADD;
         d.src_a  = SRC_A_RS1;
         d.src_b  = SRC_B_RS2;
         d.imm    = '0;
         d.rd_we  = 1'b0;
         d.mem_rd = 1'b0;
         d.mem_wr = 1'b0;
         d.branch = 1'b0;
         d.jump   = 1'b0;
         d.jalr   = 1'b0;
      end
      d.illegal = illegal;
      if (d.rd == 5'd0) begin
         d.rd_we = 1'b0;
      end
   end

   assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: one-entry output register
// behind a valid/ready handshake, with flush killing both the held and the offered entry.
module decode_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [3:0]        out_alu_op,
   output logic [1:0]        out_src_a,
   output logic [1:0]        out_src_b,
   output logic [XLEN-1:0]   out_imm,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_rd_we,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic              out_branch,
   output logic              out_jump,
   output logic              out_jalr,
   output logic [2:0]        out_funct3,
   output logic              out_illegal
);

   logic [DEC_W-1:0] dec_bits;
   decode_t          dec;
   decode_t          bundle_d, bundle_q;
   logic [XLEN-1:0]  pc_d, pc_q;
   logic             valid_d, valid_q;
   logic             accept;

   rv32i_decode_logic u_decode (
      .instr (in_instr),
      .dec_o (dec_bits)
   );

   assign dec = decode_t'(dec_bits);

   // Handshake: a word moves when valid && ready on a rising edge. Ready may
   // depend combinationally on the consumer's ready and on flush; flush also
   // acknowledges and drops the offered word so fetch never stalls on it.
   assign in_ready = flush || !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      pc_d     = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec;
         pc_d     = in_pc;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         pc_q     <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         pc_q     <= pc_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_pc      = pc_q;
   assign out_alu_op  = bundle_q.alu_op;
   assign out_src_a   = bundle_q.src_a;
   assign out_src_b   = bundle_q.src_b;
   assign out_imm     = bundle_q.imm;
   assign out_rs1     = bundle_q.rs1;
   assign out_rs2     = bundle_q.rs2;
   assign out_rd      = bundle_q.rd;
   assign out_rd_we   = bundle_q.rd_we;
   assign out_mem_rd  = bundle_q.mem_rd;
   assign out_mem_wr  = bundle_q.mem_wr;
   assign out_branch  = bundle_q.branch;
   assign out_jump    = bundle_q.jump;
   assign out_jalr    = bundle_q.jalr;
   assign out_funct3  = bundle_q.funct3;
   assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode vectors, back-pressure and flush scenarios,
// then random traffic scored against an arithmetic reference decoder.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [3:0]  out_alu_op;
   logic [1:0]  out_src_a, out_src_b;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_rd_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_jalr, out_illegal;
   logic [2:0]  out_funct3;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        rd_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic        illegal;
      logic        care;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
      .out_src_a(out_src_a), .out_src_b(out_src_b), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
      .out_jump(out_jump), .out_jalr(out_jalr), .out_funct3(out_funct3),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference decoder: ALU codes by funct3 from the opcode table, immediates
   // rebuilt with integer arithmetic from the instruction fields.
   function automatic logic [3:0] alu_base(input logic [2:0] f3);
      case (f3)
         3'd0: return 4'd0;
         3'd1: return 4'd5;
         3'd2: return 4'd8;
         3'd3: return 4'd9;
         3'd4: return 4'd4;
         3'd5: return 4'd6;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      logic ill, alt, pair;
      int sx, imm;
      logic [6:0] op, f7;
      logic [2:0] f3;
      op = ins[6:0];
      f7 = ins[31:25];
      f3 = ins[14:12];
      sx = int'($signed(ins));
      alt = (f7 == 7'h20);
      pair = (f3 == 3'd0) || (f3 == 3'd5);
      e = '0;
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
      e.care = 1'b1;
      ill = 1'b0;
      imm = 0;
      case (op)
         7'h33: begin
            ill = !((f7 == 7'h00) || (alt && pair));
            e.alu = alu_base(f3) + ((alt && pair) ? 4'd1 : 4'd0);
            e.rd_we = 1'b1;
         end
         7'h13: begin
            e.sb = 2'd1; imm = sx >>> 20; e.rd_we = 1'b1; e.alu = alu_base(f3);
            if (f3 == 3'd1) ill = (f7 != 7'h00);
            if (f3 == 3'd5) begin
               ill = !((f7 == 7'h00) || alt);
               if (alt) e.alu = 4'd7;
            end
         end
         7'h03: begin e.sb = 2'd1; imm = sx >>> 20; e.mem_rd = 1'b1; e.rd_we = 1'b1; end
         7'h23: begin e.sb = 2'd1; imm = (sx >>> 25) * 32 + int'(ins[11:7]); e.mem_wr = 1'b1; end
         7'h63: begin
            ill = (f3 == 3'd2) || (f3 == 3'd3);
            e.alu = (f3 < 3'd2) ? 4'd1 : ((f3 < 3'd6) ? 4'd8 : 4'd9);
            e.branch = 1'b1;
            imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
         end
         7'h37: begin e.sa = 2'd2; e.sb = 2'd1; imm = int'(ins[31:12]) * 4096; e.rd_we = 1'b1; end
         7'h17: begin e.sa = 2'd1; e.sb = 2'd1; imm = int'(ins[31:12]) * 4096; e.rd_we = 1'b1; end
         7'h6F: begin
            e.sa = 2'd1; e.sb = 2'd2; e.jump = 1'b1; e.rd_we = 1'b1;
            imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
         end
         7'h67: begin
            ill = (f3 != 3'd0);
            e.sa = 2'd1; e.sb = 2'd2; imm = sx >>> 20; e.jump = 1'b1; e.jalr = 1'b1; e.rd_we = 1'b1;
         end
         7'h0F: e.care = 1'b0;
         default: ill = 1'b1;
      endcase
      e.imm = 32'(imm);
      if (ill) begin
         e.alu = 4'd0; e.rd_we = 1'b0; e.mem_rd = 1'b0; e.mem_wr = 1'b0;
         e.branch = 1'b0; e.jump = 1'b0; e.jalr = 1'b0; e.illegal = 1'b1; e.care = 1'b0;
      end
      if (e.rd == 5'd0) e.rd_we = 1'b0;
      return e;
   endfunction

   function automatic exp_t act_bundle();
      exp_t a;
      a.pc = out_pc; a.alu = out_alu_op; a.sa = out_src_a; a.sb = out_src_b; a.imm = out_imm;
      a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd; a.f3 = out_funct3;
      a.rd_we = out_rd_we; a.mem_rd = out_mem_rd; a.mem_wr = out_mem_wr; a.branch = out_branch;
      a.jump = out_jump; a.jalr = out_jalr; a.illegal = out_illegal; a.care = 1'b1;
      return a;
   endfunction

   function automatic logic [127:0] snap();
      return {31'd0, out_pc, out_imm, out_alu_op, out_src_a, out_src_b, out_rs1, out_rs2, out_rd,
              out_funct3, out_rd_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_jalr, out_illegal};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0] f7;
      r = $urandom;
      case ($urandom_range(0, 2))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 11))
         0:  begin r[6:0] = 7'h33; r[31:25] = f7; end
         1:  begin r[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) r[31:25] = f7; end
         2:  r[6:0] = 7'h03;
         3:  r[6:0] = 7'h23;
         4:  r[6:0] = 7'h63;
         5:  r[6:0] = 7'h37;
         6:  r[6:0] = 7'h17;
         7:  r[6:0] = 7'h6F;
         8:  begin r[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) r[14:12] = 3'd0; end
         9:  r[6:0] = 7'h0F;
         10: r = 32'h00000073;
         default: ;
      endcase
      return r;
   endfunction

   // Scoreboard monitor: push on transfer in, pop and compare on transfer out.
   always @(negedge clk) begin : monitor
      exp_t e, a;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         chk("occupancy", 128'(out_valid), 128'(exp_q.size() != 0));
         chk("in_ready", 128'(in_ready), 128'(flush || !out_valid || out_ready));
         if (out_valid && out_ready && (exp_q.size() != 0)) begin
            e = exp_t'(exp_q.pop_front());
            a = act_bundle();
            if (!e.care) begin
               a.sa = 2'd0; a.sb = 2'd0; a.imm = 32'd0;
               e.sa = 2'd0; e.sb = 2'd0; e.imm = 32'd0;
            end
            a.care = e.care;
            chk("bundle", 128'(a), 128'(e));
         end else if (out_valid && flush && (exp_q.size() != 0)) begin
            void'(exp_q.pop_front());
         end
         if (in_valid && in_ready && !flush) begin
            exp_q.push_back(ref_decode(in_instr, in_pc));
         end
      end
   end

   // Offer one instruction with out_ready=1 and an empty or draining stage.
   task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("latency_valid", 128'(out_valid), 128'd1);
   endtask

   task automatic send_hs(input logic [31:0] instr, input logic [31:0] pc);
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1; in_instr = instr; in_pc = pc;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL hs_timeout: instr 0x%0h never accepted", instr);
      end
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [127:0] held;
      rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h100;
      flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_outputs", snap(), 128'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      send_one(32'hFFB10093, 32'h1000);
      chk("addi_alu", 128'(out_alu_op), 128'd0);
      chk("addi_src_b", 128'(out_src_b), 128'd1);
      chk("addi_imm", 128'(out_imm), 128'hFFFFFFFB);
      chk("addi_rs1", 128'(out_rs1), 128'd2);
      chk("addi_rd", 128'(out_rd), 128'd1);
      chk("addi_rd_we", 128'(out_rd_we), 128'd1);
      send_one(32'h402081B3, 32'h1004);
      chk("sub_alu", 128'(out_alu_op), 128'd1);
      chk("sub_srcs", 128'({out_src_a, out_src_b}), 128'd0);
      send_one(32'h40335293, 32'h1008);
      chk("srai_alu", 128'(out_alu_op), 128'd7);
      chk("srai_shamt", 128'(out_imm[4:0]), 128'd3);
      send_one(32'h42335293, 32'h100C);
      chk("bad_srai_illegal", 128'(out_illegal), 128'd1);
      chk("bad_srai_rd_we", 128'(out_rd_we), 128'd0);
      send_one(32'hFE20ECE3, 32'h1010);
      chk("bltu_alu", 128'(out_alu_op), 128'd9);
      chk("bltu_branch", 128'(out_branch), 128'd1);
      chk("bltu_imm", 128'(out_imm), 128'hFFFFFFF8);
      chk("bltu_rd_we", 128'(out_rd_we), 128'd0);
      send_one(32'h0100006F, 32'h1014);
      chk("jal_src_a", 128'(out_src_a), 128'd1);
      chk("jal_src_b", 128'(out_src_b), 128'd2);
      chk("jal_jump", 128'(out_jump), 128'd1);
      chk("jal_rd_we", 128'(out_rd_we), 128'd0);
      send_one(32'h00000073, 32'h1018);
      chk("ecall_illegal", 128'(out_illegal), 128'd1);
      @(posedge clk); #1;

      // Back-pressure: four streamed instructions, consumer stalls three cycles.
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               send_hs((32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13, 32'h2000 + 32'(4 * k));
            end
            in_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 20 && !out_valid; t++) begin
               @(posedge clk); #1;
            end
            chk("stall_first_valid", 128'(out_valid), 128'd1);
            held = snap();
            for (int t = 0; t < 3; t++) begin
               @(posedge clk); #1;
               chk("stall_in_ready", 128'(in_ready), 128'd0);
               chk("stall_stable", snap(), held);
            end
            out_ready = 1'b1;
         end
      join
      repeat (4) begin @(posedge clk); #1; end

      // Flush with an entry held and a new word offered in the same cycle.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h3000;
      @(posedge clk); #1;
      in_instr = 32'h00500313; in_pc = 32'h3004; flush = 1'b1;
      #1;
      chk("flush_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 128'(out_valid), 128'd0);
      out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("flush_no_ghost", 128'(out_valid), 128'd0);
      end

      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = rand_instr();
         in_pc     = $urandom & 32'hFFFFFFFC;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
      chk("drain_out_valid", 128'(out_valid), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
